// File: rtl/cpu6502_pkg.sv
// Shared types and constants for the 6502 interrupt entry logic.
package cpu6502_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH_PCH,
    ST_PUSH_PCL,
    ST_PUSH_P,
    ST_VEC_LO,
    ST_VEC_HI
  } state_e;

  typedef enum logic [1:0] {
    KIND_RES,
    KIND_NMI,
    KIND_BRK,
    KIND_IRQ
  } kind_e;

  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RES = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  localparam logic [7:0] STACK_PAGE = 8'h01;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_I = 2;
  localparam int unsigned FLAG_D = 3;
  localparam int unsigned FLAG_B = 4;
  localparam int unsigned FLAG_U = 5;
  localparam int unsigned FLAG_V = 6;
  localparam int unsigned FLAG_N = 7;

  localparam logic [7:0] MASK_I = 8'h01 << FLAG_I;
  localparam logic [7:0] MASK_B = 8'h01 << FLAG_B;
  localparam logic [7:0] MASK_U = 8'h01 << FLAG_U;

  // BRK shares the IRQ vector.
  function automatic logic [15:0] vec_base(input kind_e k);
    case (k)
      KIND_NMI: return VEC_NMI;
      KIND_RES: return VEC_RES;
      default:  return VEC_IRQ;
    endcase
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Memory bus owned by the interrupt sequencer while it is busy.
interface interrupt_sequencer_if;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        we;
  logic [7:0]  din;

  modport master (output addr, output dout, output we, input din);
  modport slave  (input addr, input dout, input we, output din);
endinterface

// File: rtl/interrupt_sequencer_nmi_edge.sv
// Registered falling-edge detector on nmi_n with a sticky pending latch.
module nmi_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic nmi_n,
  input  logic clr,
  output logic fall_c,
  output logic pend
);

  logic nmi_q, nmi_d;
  logic pend_q, pend_d;

  // A new edge wins over a simultaneous clear so it is never dropped.
  always_comb begin
    nmi_d  = nmi_n;
    fall_c = nmi_q & ~nmi_n;
    pend_d = pend_q;
    if (clr)    pend_d = 1'b0;
    if (fall_c) pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_q  <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      nmi_q  <= nmi_d;
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502 interrupt/BRK/reset entry: pushes PC and P, sets I, fetches the vector, loads PC.
module interrupt_sequencer
  import cpu6502_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   insn_done,
  input  logic                   brk_req,
  input  logic                   irq_n,
  input  logic                   nmi_n,
  input  logic [7:0]             p_q,
  input  logic [15:0]            pc,
  input  logic [7:0]             sp,
  interrupt_sequencer_if.master  bus,
  output logic                   sp_dec,
  output logic [7:0]             flag_ena,
  output logic [7:0]             flag_d,
  output logic                   pc_load,
  output logic [15:0]            pc_new,
  output logic                   busy
);

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic        brk_q, brk_d;
  logic [7:0]  vec_lo_q, vec_lo_d;

  logic        nmi_fall_c;
  logic        nmi_pend;
  logic        nmi_clr_c;
  logic        in_push_c;

  logic [15:0] addr_c;
  logic [7:0]  dout_c;
  logic        we_c;

  assign nmi_clr_c = (state_q == ST_VEC_LO) && (kind_q == KIND_NMI);
  assign in_push_c = (state_q == ST_PUSH_PCH) || (state_q == ST_PUSH_PCL) ||
                     (state_q == ST_PUSH_P);

  nmi_edge_detect u_nmi (
    .clk    (clk),
    .rst    (rst),
    .nmi_n  (nmi_n),
    .clr    (nmi_clr_c),
    .fall_c (nmi_fall_c),
    .pend   (nmi_pend)
  );

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    brk_d    = brk_q;
    vec_lo_d = vec_lo_q;
    addr_c   = 16'h0000;
    dout_c   = 8'h00;
    we_c     = 1'b0;
    sp_dec   = 1'b0;
    flag_ena = 8'h00;
    flag_d   = 8'h00;
    pc_load  = 1'b0;
    pc_new   = 16'h0000;
    busy     = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (insn_done) begin
          if (nmi_pend) begin
            kind_d  = KIND_NMI;
            brk_d   = 1'b0;
            state_d = ST_PUSH_PCH;
          end else if (brk_req) begin
            kind_d  = KIND_BRK;
            brk_d   = 1'b1;
            state_d = ST_PUSH_PCH;
          end else if (!irq_n && !p_q[FLAG_I]) begin
            kind_d  = KIND_IRQ;
            brk_d   = 1'b0;
            state_d = ST_PUSH_PCH;
          end
        end
      end
      ST_PUSH_PCH: begin
        addr_c  = {STACK_PAGE, sp};
        dout_c  = pc[15:8];
        we_c    = 1'b1;
        sp_dec  = 1'b1;
        state_d = ST_PUSH_PCL;
      end
      ST_PUSH_PCL: begin
        addr_c  = {STACK_PAGE, sp};
        dout_c  = pc[7:0];
        we_c    = 1'b1;
        sp_dec  = 1'b1;
        state_d = ST_PUSH_P;
      end
      ST_PUSH_P: begin
        // B comes from the accepted request, so a later NMI hijack keeps it.
        addr_c   = {STACK_PAGE, sp};
        dout_c   = (p_q & ~MASK_B) | MASK_U | (brk_q ? MASK_B : 8'h00);
        we_c     = 1'b1;
        sp_dec   = 1'b1;
        flag_ena = MASK_I;
        flag_d   = MASK_I;
        state_d  = ST_VEC_LO;
      end
      ST_VEC_LO: begin
        addr_c   = vec_base(kind_q);
        vec_lo_d = bus.din;
        if (kind_q == KIND_RES) begin
          flag_ena = MASK_I;
          flag_d   = MASK_I;
        end
        state_d  = ST_VEC_HI;
      end
      ST_VEC_HI: begin
        addr_c  = vec_base(kind_q) + 16'd1;
        pc_new  = {bus.din, vec_lo_q};
        pc_load = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // NMI arriving during the pushes of a BRK/IRQ redirects the vector fetch.
    if (in_push_c && (kind_q == KIND_BRK || kind_q == KIND_IRQ) &&
        (nmi_pend || nmi_fall_c)) begin
      kind_d = KIND_NMI;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_VEC_LO;
      kind_q   <= KIND_RES;
      brk_q    <= 1'b0;
      vec_lo_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      brk_q    <= brk_d;
      vec_lo_q <= vec_lo_d;
    end
  end

  assign bus.addr = addr_c;
  assign bus.dout = dout_c;
  assign bus.we   = we_c;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Randomized and directed checks of interrupt_sequencer against a transaction-level model.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        insn_done;
  logic        brk_req;
  logic        irq_n;
  logic        nmi_n;
  logic [7:0]  p_q;
  logic [15:0] pc;
  logic [7:0]  sp;
  logic        sp_dec;
  logic [7:0]  flag_ena;
  logic [7:0]  flag_d;
  logic        pc_load;
  logic [15:0] pc_new;
  logic        busy;

  logic [7:0]  vec_mem [8];

  int n_checks = 0;
  int n_fail   = 0;

  interrupt_sequencer_if bus ();

  interrupt_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .insn_done (insn_done),
    .brk_req   (brk_req),
    .irq_n     (irq_n),
    .nmi_n     (nmi_n),
    .p_q       (p_q),
    .pc        (pc),
    .sp        (sp),
    .bus       (bus),
    .sp_dec    (sp_dec),
    .flag_ena  (flag_ena),
    .flag_d    (flag_d),
    .pc_load   (pc_load),
    .pc_new    (pc_new),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Vector ROM at FFFA..FFFF, filler elsewhere.
  always_comb begin
    if (bus.addr >= 16'hFFFA) bus.din = vec_mem[bus.addr[2:0]];
    else                      bus.din = 8'hEE;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset edge followed by the two-cycle reset vector fetch.
  task automatic reset_path();
    logic [15:0] want;
    rst = 1'b1; insn_done = 1'b0; brk_req = 1'b0; irq_n = 1'b1; nmi_n = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_eq("rst_busy",  32'(busy), 32'd1);
    check_eq("rst_addr",  32'(bus.addr), 32'hFFFC);
    check_eq("rst_we",    32'(bus.we), 32'd0);
    check_eq("rst_spdec", 32'(sp_dec), 32'd0);
    check_eq("rst_pcld",  32'(pc_load), 32'd0);
    check_eq("rst_fena",  32'(flag_ena), 32'h04);
    check_eq("rst_fd",    32'(flag_d), 32'h04);
    check_eq("rst_dout",  32'(bus.dout), 32'h00);
    check_eq("rst_pcnew", 32'(pc_new), 32'h0000);
    want = {vec_mem[5], vec_mem[4]};
    step(); #1;
    check_eq("rhi_busy",  32'(busy), 32'd1);
    check_eq("rhi_addr",  32'(bus.addr), 32'hFFFD);
    check_eq("rhi_we",    32'(bus.we), 32'd0);
    check_eq("rhi_fena",  32'(flag_ena), 32'h00);
    check_eq("rhi_pcld",  32'(pc_load), 32'd1);
    check_eq("rhi_pcnew", 32'(pc_new), 32'(want));
    step(); #1;
    check_eq("rend_busy", 32'(busy), 32'd0);
    check_eq("rend_pcld", 32'(pc_load), 32'd0);
  endtask

  // One request set at an insn_done; hijack_at/rst_at name a push cycle (0..2) or -1.
  task automatic run_seq(input bit nmi, input bit brk, input bit irq_low,
                         input int hijack_at, input int rst_at);
    int          k;
    bit          hij;
    logic [7:0]  sp0, spx, pexp;
    logic [15:0] base;
    nmi_n = 1'b1; insn_done = 1'b0; brk_req = 1'b0; irq_n = 1'b1;
    step();
    if (nmi) begin
      nmi_n = 1'b0;
      step();
    end
    check_eq("pre_busy", 32'(busy), 32'd0);
    // 0 none, 1 NMI, 2 BRK, 3 IRQ
    k = nmi ? 1 : brk ? 2 : (irq_low && !p_q[2]) ? 3 : 0;
    insn_done = 1'b1; brk_req = brk; irq_n = ~irq_low;
    step();
    insn_done = 1'b0; brk_req = 1'b0; irq_n = 1'b1;
    #1;
    if (k == 0) begin
      check_eq("none_busy", 32'(busy), 32'd0);
      check_eq("none_we", 32'(bus.we), 32'd0);
      return;
    end
    hij  = (k > 1) && (hijack_at >= 0);
    base = (k == 1 || hij) ? 16'hFFFA : 16'hFFFE;
    sp0  = sp;
    pexp = (p_q & 8'hEF) | 8'h20 | ((k == 2) ? 8'h10 : 8'h00);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        step();
        if (i <= 3) sp = sp - 8'd1;
        #1;
      end
      check_eq("seq_busy", 32'(busy), 32'd1);
      if (i < 3) begin
        spx = sp0 - 8'(i);
        check_eq("push_addr", 32'(bus.addr), 32'({8'h01, spx}));
        check_eq("push_dout", 32'(bus.dout),
                 32'((i == 0) ? pc[15:8] : (i == 1) ? pc[7:0] : pexp));
        check_eq("push_we", 32'(bus.we), 32'd1);
        check_eq("push_spdec", 32'(sp_dec), 32'd1);
        check_eq("push_fena", 32'(flag_ena), (i == 2) ? 32'h04 : 32'h00);
        if (i == 2) check_eq("push_fd", 32'(flag_d), 32'h04);
        check_eq("push_pcld", 32'(pc_load), 32'd0);
        if (hij && i == hijack_at) nmi_n = 1'b0;
        if (i == rst_at) begin
          reset_path();
          return;
        end
      end else if (i == 3) begin
        check_eq("vlo_addr", 32'(bus.addr), 32'(base));
        check_eq("vlo_we", 32'(bus.we), 32'd0);
        check_eq("vlo_spdec", 32'(sp_dec), 32'd0);
        check_eq("vlo_fena", 32'(flag_ena), 32'h00);
        check_eq("vlo_pcld", 32'(pc_load), 32'd0);
      end else begin
        check_eq("vhi_addr", 32'(bus.addr), 32'(base + 16'd1));
        check_eq("vhi_we", 32'(bus.we), 32'd0);
        check_eq("vhi_pcld", 32'(pc_load), 32'd1);
        check_eq("vhi_pcnew", 32'(pc_new), 32'({vec_mem[3'(base[2:0] + 3'd1)], vec_mem[base[2:0]]}));
      end
    end
    step();
    check_eq("end_busy", 32'(busy), 32'd0);
    check_eq("end_pcld", 32'(pc_load), 32'd0);
    check_eq("end_we", 32'(bus.we), 32'd0);
  endtask

  initial begin
    rst = 1'b1; insn_done = 1'b0; brk_req = 1'b0; irq_n = 1'b1; nmi_n = 1'b1;
    p_q = 8'h00; pc = 16'h0000; sp = 8'hFD;
    for (int i = 0; i < 8; i++) vec_mem[i] = 8'h00;
    vec_mem[4] = 8'h34;
    vec_mem[5] = 8'h12;
    reset_path();

    vec_mem[2] = 8'hA2; vec_mem[3] = 8'hA3;
    vec_mem[6] = 8'hE6; vec_mem[7] = 8'hE7;

    p_q = 8'h00; pc = 16'h8003; sp = 8'hFD;
    run_seq(1'b0, 1'b0, 1'b1, -1, -1);
    p_q = 8'h04;
    run_seq(1'b0, 1'b0, 1'b1, -1, -1);
    p_q = 8'hC3; pc = 16'h1234; sp = 8'hF0;
    run_seq(1'b0, 1'b1, 1'b0, -1, -1);
    p_q = 8'h00; pc = 16'hBEEF;
    run_seq(1'b0, 1'b1, 1'b0, 1, -1);
    run_seq(1'b0, 1'b0, 1'b0, -1, -1);
    run_seq(1'b1, 1'b1, 1'b1, -1, -1);
    run_seq(1'b0, 1'b1, 1'b1, -1, -1);
    p_q = 8'h10; sp = 8'h01;
    run_seq(1'b0, 1'b0, 1'b1, -1, -1);
    p_q = 8'h00;
    run_seq(1'b0, 1'b0, 1'b1, 2, -1);
    run_seq(1'b0, 1'b0, 1'b1, -1, 1);

    for (int t = 0; t < 60; t++) begin
      bit nmi, brk, irql;
      int hj;
      for (int i = 0; i < 8; i++) vec_mem[i] = 8'($urandom);
      p_q  = 8'($urandom);
      pc   = 16'($urandom);
      sp   = 8'($urandom);
      nmi  = ($urandom_range(0, 3) == 0);
      brk  = 1'($urandom);
      irql = 1'($urandom);
      hj   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2)) : -1;
      run_seq(nmi, brk, irql, hj, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
